// File: rtl/tor_rx_frame_parser.sv
// rtl/tor_rx_frame_parser.sv - RX frame parser: destination MAC filter, 14-byte header strip and payload realign
// Optional feature macro: SRRNET_RX_BROADCAST_EN (also accept the all-ones broadcast destination)
module tor_rx_frame_parser #(
  parameter logic [47:0] P_MY_TOR_MAC = 48'h8D_BC_5C_4A_00_00,
  parameter int          P_CNT_W      = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [63:0]        s_axis_rx_tdata,
  input  logic [7:0]         s_axis_rx_tkeep,
  input  logic               s_axis_rx_tlast,
  input  logic               s_axis_rx_tvalid,
  output logic [63:0]        m_axis_tdata,
  output logic [7:0]         m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  output logic [47:0]        o_src_mac,
  output logic [15:0]        o_eth_type,
  output logic               o_hdr_valid,
  output logic [P_CNT_W-1:0] o_rx_frame_cnt,
  output logic [P_CNT_W-1:0] o_drop_cnt,
  output logic [15:0]        o_runt_cnt
);

  typedef enum logic [2:0] {S_HDR0, S_HDR1, S_PAY, S_FLUSH, S_DROP} state_t;

  function automatic logic [3:0] f_keep_cnt(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'd0, keep[i]};
    return cnt;
  endfunction

  function automatic logic [7:0] f_keep_mask(input logic [3:0] cnt);
    return ~(8'hFF >> cnt);
  endfunction

  function automatic logic [63:0] f_byte_mask(input logic [7:0] keep);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{keep[i]}};
    return m;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_carry, w_carry_nxt;
  logic [3:0]           r_flush_n, w_flush_n_nxt;
  logic                 r_first, w_first_nxt;
  logic [47:0]          r_src_mac, w_src_mac_nxt;
  logic [15:0]          r_eth_type, w_eth_type_nxt;
  logic [63:0]          r_tdata, w_raw_data, w_tdata_nxt;
  logic [7:0]           r_tkeep, w_keep_nxt;
  logic                 r_tlast, w_last_nxt;
  logic                 r_tvalid, w_valid_nxt;
  logic                 r_hdr_valid, w_hdr_nxt;
  logic [P_CNT_W-1:0]   r_rx_cnt, r_drop_cnt;
  logic [15:0]          r_runt_cnt;
  logic                 w_inc_rx, w_inc_drop, w_inc_runt;
  logic [3:0]           w_n;
  logic                 w_dst_match;

  assign w_n = f_keep_cnt(s_axis_rx_tkeep);

`ifdef SRRNET_RX_BROADCAST_EN
  assign w_dst_match = (s_axis_rx_tdata[63:16] == P_MY_TOR_MAC) ||
                       (s_axis_rx_tdata[63:16] == 48'hFFFF_FFFF_FFFF);
`else
  assign w_dst_match = (s_axis_rx_tdata[63:16] == P_MY_TOR_MAC);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_carry_nxt    = r_carry;
    w_flush_n_nxt  = r_flush_n;
    w_first_nxt    = r_first;
    w_src_mac_nxt  = r_src_mac;
    w_eth_type_nxt = r_eth_type;
    w_raw_data     = '0;
    w_keep_nxt     = '0;
    w_last_nxt     = 1'b0;
    w_valid_nxt    = 1'b0;
    w_hdr_nxt      = 1'b0;
    w_inc_rx       = 1'b0;
    w_inc_drop     = 1'b0;
    w_inc_runt     = 1'b0;
    case (r_state)
      S_HDR0, S_FLUSH: begin
        // FLUSH drains only the stored tail, so the next frame's beat 0 is parsed in parallel
        if (r_state == S_FLUSH) begin
          w_raw_data  = {r_carry, 48'h0};
          w_keep_nxt  = f_keep_mask(r_flush_n);
          w_last_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_inc_rx    = 1'b1;
          w_state_nxt = S_HDR0;
        end
        if (s_axis_rx_tvalid) begin
          w_carry_nxt = s_axis_rx_tdata[15:0];
          if (s_axis_rx_tlast) begin
            w_inc_runt  = 1'b1;
            w_state_nxt = S_HDR0;
          end else if (w_dst_match) begin
            w_state_nxt = S_HDR1;
          end else begin
            w_state_nxt = S_DROP;
          end
        end
      end
      S_HDR1: begin
        if (s_axis_rx_tvalid) begin
          w_src_mac_nxt  = {r_carry, s_axis_rx_tdata[63:32]};
          w_eth_type_nxt = s_axis_rx_tdata[31:16];
          w_carry_nxt    = s_axis_rx_tdata[15:0];
          if (s_axis_rx_tlast) begin
            w_state_nxt = S_HDR0;
            if (w_n <= 4'd6) begin
              w_inc_runt = 1'b1;
            end else begin
              w_raw_data  = {s_axis_rx_tdata[15:0], 48'h0};
              w_keep_nxt  = f_keep_mask(w_n - 4'd6);
              w_last_nxt  = 1'b1;
              w_valid_nxt = 1'b1;
              w_hdr_nxt   = 1'b1;
              w_inc_rx    = 1'b1;
            end
          end else begin
            w_first_nxt = 1'b1;
            w_state_nxt = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (s_axis_rx_tvalid) begin
          w_valid_nxt = 1'b1;
          w_hdr_nxt   = r_first;
          w_first_nxt = 1'b0;
          w_raw_data  = {r_carry, s_axis_rx_tdata[63:16]};
          // Masked so a 1-byte tail leaves its unused byte zero in the FLUSH beat
          w_carry_nxt = s_axis_rx_tdata[15:0] &
                        {{8{s_axis_rx_tkeep[1]}}, {8{s_axis_rx_tkeep[0]}}};
          if (!s_axis_rx_tlast) begin
            w_keep_nxt = 8'hFF;
          end else if (w_n <= 4'd6) begin
            w_keep_nxt  = f_keep_mask(w_n + 4'd2);
            w_last_nxt  = 1'b1;
            w_inc_rx    = 1'b1;
            w_state_nxt = S_HDR0;
          end else begin
            w_keep_nxt    = 8'hFF;
            w_flush_n_nxt = w_n - 4'd6;
            w_state_nxt   = S_FLUSH;
          end
        end
      end
      S_DROP: begin
        if (s_axis_rx_tvalid && s_axis_rx_tlast) begin
          w_inc_drop  = 1'b1;
          w_state_nxt = S_HDR0;
        end
      end
      default: w_state_nxt = S_HDR0;
    endcase
  end

  assign w_tdata_nxt = w_raw_data & f_byte_mask(w_keep_nxt);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_HDR0;
      r_carry     <= '0;
      r_flush_n   <= '0;
      r_first     <= 1'b0;
      r_src_mac   <= '0;
      r_eth_type  <= '0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_hdr_valid <= 1'b0;
      r_rx_cnt    <= '0;
      r_drop_cnt  <= '0;
      r_runt_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_carry     <= w_carry_nxt;
      r_flush_n   <= w_flush_n_nxt;
      r_first     <= w_first_nxt;
      r_src_mac   <= w_src_mac_nxt;
      r_eth_type  <= w_eth_type_nxt;
      r_tdata     <= w_tdata_nxt;
      r_tkeep     <= w_keep_nxt;
      r_tlast     <= w_last_nxt;
      r_tvalid    <= w_valid_nxt;
      r_hdr_valid <= w_hdr_nxt;
      r_rx_cnt    <= r_rx_cnt + {{(P_CNT_W-1){1'b0}}, w_inc_rx};
      r_drop_cnt  <= r_drop_cnt + {{(P_CNT_W-1){1'b0}}, w_inc_drop};
      r_runt_cnt  <= r_runt_cnt + {15'd0, w_inc_runt};
    end
  end

  assign m_axis_tdata   = r_tdata;
  assign m_axis_tkeep   = r_tkeep;
  assign m_axis_tlast   = r_tlast;
  assign m_axis_tvalid  = r_tvalid;
  assign o_src_mac      = r_src_mac;
  assign o_eth_type     = r_eth_type;
  assign o_hdr_valid    = r_hdr_valid;
  assign o_rx_frame_cnt = r_rx_cnt;
  assign o_drop_cnt     = r_drop_cnt;
  assign o_runt_cnt     = r_runt_cnt;

endmodule

// File: tb/tb_tor_rx_frame_parser.sv
// tb/tb_tor_rx_frame_parser.sv - self-checking bench for tor_rx_frame_parser (byte-level frame model + scoreboard)
`timescale 1ns/1ps
module tb_tor_rx_frame_parser;
  localparam logic [47:0] MY_MAC    = 48'h8DBC5C4A0000;
  localparam logic [47:0] BC_MAC    = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER_MAC = 48'h020000000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tvalid;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid;
  logic [47:0] o_src_mac;
  logic [15:0] o_eth_type;
  logic        o_hdr_valid;
  logic [31:0] o_rx_frame_cnt, o_drop_cnt;
  logic [15:0] o_runt_cnt;

  always #5 clk = ~clk;

  tor_rx_frame_parser dut (
    .i_clk(clk), .i_rst(rst),
    .s_axis_rx_tdata(s_tdata), .s_axis_rx_tkeep(s_tkeep),
    .s_axis_rx_tlast(s_tlast), .s_axis_rx_tvalid(s_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .o_src_mac(o_src_mac), .o_eth_type(o_eth_type), .o_hdr_valid(o_hdr_valid),
    .o_rx_frame_cnt(o_rx_frame_cnt), .o_drop_cnt(o_drop_cnt), .o_runt_cnt(o_runt_cnt)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        hdr;
    logic [47:0] src;
    logic [15:0] eth;
    int          edge_no;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      e;
  int         m_rx = 0, m_drop = 0, m_runt = 0;
  int         seen_beats = 0;
  logic [7:0] seen_last_keep = 8'h00;
  bit         mon_en = 1'b0;
  logic [7:0] fb [0:127];
  int         flen;

  // Scoreboard: every output beat must match the model's next beat, including the cycle it appears in
  always @(negedge clk) begin
    if (mon_en && !rst && m_axis_tvalid) begin
      seen_beats++;
      seen_last_keep = m_axis_tkeep;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat data=%h keep=%h last=%b cyc=%0d (no beat expected)",
                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, cyc);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last ||
            o_hdr_valid !== e.hdr || o_src_mac !== e.src || o_eth_type !== e.eth || cyc != e.edge_no) begin
          errors++;
          $display("FAIL out_beat got data=%h keep=%h last=%b hdr=%b src=%h eth=%h cyc=%0d exp data=%h keep=%h last=%b hdr=%b src=%h eth=%h cyc=%0d",
                   m_axis_tdata, m_axis_tkeep, m_axis_tlast, o_hdr_valid, o_src_mac, o_eth_type, cyc,
                   e.data, e.keep, e.last, e.hdr, e.src, e.eth, e.edge_no);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  function automatic int keep_count(input logic [7:0] k);
    int c = 0;
    for (int i = 0; i < 8; i++) if (k[i]) c++;
    return c;
  endfunction

  function automatic logic [7:0] top_mask(input int n);
    logic [7:0] m = 8'h00;
    for (int i = 0; i < n; i++) m[7-i] = 1'b1;
    return m;
  endfunction

  // Fill the frame buffer; bytes past the frame end stay random so zeroing of unused lanes is exercised
  task automatic build(input logic [47:0] dst, input int nbeats, input logic [7:0] lk, input bit seq);
    logic [47:0] src;
    src = {$urandom, $urandom};
    flen = 8 * (nbeats - 1) + keep_count(lk);
    for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      fb[k]     = dst[47-8*k -: 8];
      fb[6 + k] = src[47-8*k -: 8];
    end
    if (seq) for (int k = 14; k < 128; k++) fb[k] = 8'(k - 14);
  endtask

  task automatic model(input int nbeats, input int n, input int e0);
    logic [47:0] dst, src;
    logic [15:0] eth;
    bit match;
    int p, nb, cnt;
    beat_t b;
    for (int k = 0; k < 6; k++) begin
      dst[47-8*k -: 8] = fb[k];
      src[47-8*k -: 8] = fb[6 + k];
    end
    eth = {fb[12], fb[13]};
    match = (dst == MY_MAC);
`ifdef SRRNET_RX_BROADCAST_EN
    if (dst == BC_MAC) match = 1'b1;
`endif
    if (nbeats == 1) m_runt++;
    else if (!match) m_drop++;
    else if (flen < 15) m_runt++;
    else begin
      p  = flen - 14;
      nb = (p + 7) / 8;
      for (int j = 0; j < nb; j++) begin
        cnt = (j == nb - 1) ? p - 8 * j : 8;
        b.data = '0;
        for (int k = 0; k < cnt; k++) b.data[63-8*k -: 8] = fb[14 + 8 * j + k];
        b.keep = top_mask(cnt);
        b.last = (j == nb - 1);
        b.hdr  = (j == 0);
        b.src  = src;
        b.eth  = eth;
        if (j == nb - 1) b.edge_no = e0 + nbeats - 1 + ((n > 6 && nbeats >= 3) ? 1 : 0);
        else             b.edge_no = e0 + j + 2;
        exp_q.push_back(b);
      end
      m_rx++;
    end
  endtask

  task automatic drive_beat(input int i, input bit last, input logic [7:0] k);
    for (int b = 0; b < 8; b++) s_tdata[63-8*b -: 8] = fb[8 * i + b];
    s_tkeep  = k;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tkeep  = 8'h00;
    s_tdata  = {$urandom, $urandom};
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int nbeats, input logic [7:0] lk, input int gap);
    model(nbeats, keep_count(lk), cyc + 1);
    for (int i = 0; i < nbeats; i++)
      drive_beat(i, i == nbeats - 1, (i == nbeats - 1) ? lk : 8'hFF);
    idle(gap);
  endtask

  typedef struct {
    logic [47:0] dst;
    int          beats;
    logic [7:0]  lk;
    int          gap;
    int          exp_beats;
    logic [7:0]  exp_lk;
    int          d_rx, d_drop, d_runt;
  } vec_t;

  vec_t vt[12];
  int   t_rx, t_drop, t_runt, pend_beats;
  logic [7:0] pend_lk;

  initial begin
    vt[0]  = '{MY_MAC,    5, 8'hC0, 3, 3, 8'hF0, 1, 0, 0};
    vt[1]  = '{MY_MAC,    4, 8'hF0, 3, 2, 8'hFC, 1, 0, 0};
    vt[2]  = '{MY_MAC,    4, 8'hFE, 0, 3, 8'h80, 1, 0, 0};
    vt[3]  = '{MY_MAC,    3, 8'hFF, 3, 2, 8'hC0, 1, 0, 0};
    vt[4]  = '{OTHER_MAC, 5, 8'hFF, 3, 0, 8'h00, 0, 1, 0};
    vt[5]  = '{MY_MAC,    1, 8'hFF, 3, 0, 8'h00, 0, 0, 1};
    vt[6]  = '{MY_MAC,    2, 8'hFC, 3, 0, 8'h00, 0, 0, 1};
    vt[7]  = '{MY_MAC,    2, 8'hFF, 3, 1, 8'hC0, 1, 0, 0};
    vt[8]  = '{MY_MAC,    2, 8'hFE, 3, 1, 8'h80, 1, 0, 0};
    vt[9]  = '{OTHER_MAC, 2, 8'h80, 3, 0, 8'h00, 0, 1, 0};
`ifdef SRRNET_RX_BROADCAST_EN
    vt[10] = '{BC_MAC,    3, 8'hFF, 3, 2, 8'hC0, 1, 0, 0};
`else
    vt[10] = '{BC_MAC,    3, 8'hFF, 3, 0, 8'h00, 0, 1, 0};
`endif
    vt[11] = '{MY_MAC,    3, 8'h80, 3, 1, 8'hE0, 1, 0, 0};

    rst = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 8'h00; s_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata", m_axis_tdata, 64'd0);
    chk("rst_tkeep_tlast_hdr", {55'd0, m_axis_tkeep, m_axis_tlast, o_hdr_valid}, 64'd0);
    chk("rst_src_eth", {o_src_mac, o_eth_type}, 64'd0);
    chk("rst_counters", {o_rx_frame_cnt, o_drop_cnt} | {48'd0, o_runt_cnt}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    t_rx = 0; t_drop = 0; t_runt = 0; pend_beats = 0; pend_lk = 8'h00;
    for (int v = 0; v < 12; v++) begin
      if (pend_beats == 0 && seen_beats == 0) seen_last_keep = 8'h00;
      build(vt[v].dst, vt[v].beats, vt[v].lk, 1'b1);
      send(vt[v].beats, vt[v].lk, vt[v].gap);
      t_rx += vt[v].d_rx; t_drop += vt[v].d_drop; t_runt += vt[v].d_runt;
      pend_beats += vt[v].exp_beats;
      if (vt[v].exp_beats > 0) pend_lk = vt[v].exp_lk;
      if (vt[v].gap > 0) begin
        chk($sformatf("vec%0d_beats", v), 64'(seen_beats), 64'(pend_beats));
        if (pend_beats > 0) chk($sformatf("vec%0d_last_keep", v), {56'd0, seen_last_keep}, {56'd0, pend_lk});
        chk($sformatf("vec%0d_rx_cnt", v), {32'd0, o_rx_frame_cnt}, 64'(t_rx));
        chk($sformatf("vec%0d_drop_cnt", v), {32'd0, o_drop_cnt}, 64'(t_drop));
        chk($sformatf("vec%0d_runt_cnt", v), {48'd0, o_runt_cnt}, 64'(t_runt));
        seen_beats = 0; pend_beats = 0;
      end
    end

    for (int f = 0; f < 150; f++) begin
      logic [47:0] dst;
      int sel, n;
      sel = $urandom_range(0, 3);
      case (sel)
        0: dst = MY_MAC;
        1: dst = BC_MAC;
        2: dst = MY_MAC ^ (48'd1 << $urandom_range(0, 47));
        default: dst = {$urandom, $urandom};
      endcase
      n = $urandom_range(1, 8);
      build(dst, $urandom_range(1, 8), top_mask(n), 1'b0);
      send((flen + 7) / 8 > 0 ? (flen - n) / 8 + 1 : 1, top_mask(n), $urandom_range(0, 2));
    end
    idle(4);
    chk("rand_rx_cnt", {32'd0, o_rx_frame_cnt}, 64'(m_rx));
    chk("rand_drop_cnt", {32'd0, o_drop_cnt}, 64'(m_drop));
    chk("rand_runt_cnt", {48'd0, o_runt_cnt}, 64'(m_runt));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    mon_en = 1'b0;
    build(MY_MAC, 6, 8'hFF, 1'b0);
    drive_beat(0, 1'b0, 8'hFF);
    drive_beat(1, 1'b0, 8'hFF);
    drive_beat(2, 1'b0, 8'hFF);
    rst = 1'b1;
    drive_beat(3, 1'b0, 8'hFF);
    rst = 1'b0;
    idle(0);
    chk("midrst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("midrst_tdata", m_axis_tdata, 64'd0);
    chk("midrst_hdr_keep", {55'd0, m_axis_tkeep, m_axis_tlast, o_hdr_valid}, 64'd0);
    chk("midrst_src", {16'd0, o_src_mac}, 64'd0);
    chk("midrst_rx_cnt", {32'd0, o_rx_frame_cnt}, 64'd0);
    exp_q.delete();
    m_rx = 0; m_drop = 0; m_runt = 0;
    idle(2);
    mon_en = 1'b1;
    build(MY_MAC, 4, 8'hF0, 1'b0);
    send(4, 8'hF0, 4);
    chk("post_rst_rx_cnt", {32'd0, o_rx_frame_cnt}, 64'd1);
    chk("post_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
